// File: rtl/quant_stream_multi.sv
// Streaming multi-channel DCT coefficient quantizer: per-channel/per-index reciprocal
// multiply, round half away from zero, symmetric saturation, 3-stage valid/ready pipe.
module quant_stream_multi #(
  parameter int NUM_CH  = 3,
  parameter int IN_W    = 11,
  parameter int OUT_W   = 11,
  parameter int RECIP_W = 16,
  parameter int SHIFT   = 12,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tbl_wr_en,
  input  logic [CH_W-1:0]           tbl_wr_ch,
  input  logic [5:0]                tbl_wr_addr,
  input  logic [RECIP_W-1:0]        tbl_wr_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [IN_W-1:0]    s_data,
  input  logic [CH_W-1:0]           s_ch,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [OUT_W-1:0]   m_data,
  output logic [CH_W-1:0]           m_ch,
  output logic                      m_last,
  output logic                      m_sat,
  output logic                      err_ch
);

  localparam int PW = IN_W + RECIP_W + 1;
  localparam logic [CH_W:0]        NUM_CH_L  = (CH_W+1)'(NUM_CH);
  localparam logic [RECIP_W-1:0]   RECIP_ONE = RECIP_W'(2**SHIFT);
  localparam logic [PW-1:0]        HALF      = PW'(2**(SHIFT-1));
  localparam logic [PW-1:0]        MAXV      = PW'(2**(OUT_W-1) - 1);
  localparam logic [OUT_W-1:0]     MAXO      = OUT_W'(2**(OUT_W-1) - 1);

  logic advance, in_xfer, ch_bad;
  logic [CH_W-1:0] ch_eff;

  logic [5:0]       idx_q;
  logic [CH_W-1:0]  blk_ch_q;
  logic             err_ch_q;
  logic [RECIP_W-1:0] tbl_q [NUM_CH][64];

  logic                      v1_q, last1_q;
  logic signed [IN_W-1:0]    d1_q;
  logic [RECIP_W-1:0]        r1_q;
  logic [CH_W-1:0]           ch1_q;

  logic                      v2_q, last2_q;
  logic signed [PW-1:0]      p2_q, p2_d;
  logic [CH_W-1:0]           ch2_q;

  logic                      v3_q, last3_q, sat3_q;
  logic signed [OUT_W-1:0]   data3_q;
  logic [CH_W-1:0]           ch3_q;

  logic [PW-1:0]    mag, rnd, qmag;
  logic [OUT_W-1:0] qo, res_d;
  logic             sat_d;

  assign advance = !v3_q || m_ready;
  assign s_ready = advance;
  assign in_xfer = s_valid && advance;

  // Index 0 of a block uses the incoming channel directly; later indices use the latched one.
  always_comb begin
    ch_bad = ({1'b0, s_ch} >= NUM_CH_L);
    ch_eff = blk_ch_q;
    if (idx_q == 6'd0) ch_eff = ch_bad ? '0 : s_ch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int a = 0; a < 64; a++)
          tbl_q[c][a] <= RECIP_ONE;
    end else if (tbl_wr_en && ({1'b0, tbl_wr_ch} < NUM_CH_L)) begin
      tbl_q[tbl_wr_ch][tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      blk_ch_q <= '0;
      err_ch_q <= 1'b0;
    end else if (in_xfer) begin
      idx_q <= idx_q + 6'd1;
      if (idx_q == 6'd0) begin
        blk_ch_q <= ch_eff;
        if (ch_bad) err_ch_q <= 1'b1;
      end
    end
  end

  assign p2_d = PW'(d1_q) * PW'($signed({1'b0, r1_q}));

  // Round on magnitude so positive and negative halves round away from zero alike.
  always_comb begin
    mag   = p2_q[PW-1] ? -p2_q : p2_q;
    rnd   = mag + HALF;
    qmag  = rnd >> SHIFT;
    sat_d = (qmag > MAXV);
    qo    = sat_d ? MAXO : qmag[OUT_W-1:0];
    res_d = p2_q[PW-1] ? -qo : qo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; d1_q <= '0; r1_q <= '0; ch1_q <= '0; last1_q <= 1'b0;
      v2_q <= 1'b0; p2_q <= '0; ch2_q <= '0; last2_q <= 1'b0;
      v3_q <= 1'b0; data3_q <= '0; ch3_q <= '0; last3_q <= 1'b0; sat3_q <= 1'b0;
    end else if (advance) begin
      v1_q    <= in_xfer;
      d1_q    <= s_data;
      r1_q    <= tbl_q[ch_eff][idx_q];
      ch1_q   <= ch_eff;
      last1_q <= (idx_q == 6'd63);
      v2_q    <= v1_q;
      p2_q    <= p2_d;
      ch2_q   <= ch1_q;
      last2_q <= last1_q;
      v3_q    <= v2_q;
      data3_q <= res_d;
      ch3_q   <= ch2_q;
      last3_q <= last2_q;
      sat3_q  <= sat_d;
    end
  end

  assign m_valid = v3_q;
  assign m_data  = data3_q;
  assign m_ch    = ch3_q;
  assign m_last  = last3_q;
  assign m_sat   = sat3_q;
  assign err_ch  = err_ch_q;

endmodule

// File: tb/tb_quant_stream_multi.sv
// Scoreboard bench for quant_stream_multi: a negedge input monitor feeds a reference
// model into an expectation queue; a separate output monitor pops and compares.
module tb_quant_stream_multi;
  localparam int NUM_CH = 3, IN_W = 11, OUT_W = 8, RECIP_W = 16, SHIFT = 12, CH_W = 2;
  localparam int MAXV = 2**(OUT_W-1) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic tbl_wr_en = 1'b0;
  logic [CH_W-1:0] tbl_wr_ch = '0;
  logic [5:0] tbl_wr_addr = '0;
  logic [RECIP_W-1:0] tbl_wr_data = '0;
  logic s_valid = 1'b0, s_ready;
  logic signed [IN_W-1:0] s_data = '0;
  logic [CH_W-1:0] s_ch = '0;
  logic m_valid, m_ready = 1'b1, m_last, m_sat, err_ch;
  logic signed [OUT_W-1:0] m_data;
  logic [CH_W-1:0] m_ch;

  quant_stream_multi #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W),
                       .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_ch(tbl_wr_ch),
    .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_last(m_last), .m_sat(m_sat), .err_ch(err_ch));

  always #5 clk = ~clk;

  typedef struct { int data; int ch; bit last; bit sat; } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_errs = 0;
  int cyc = 0;
  int mdl_tbl [NUM_CH][64];
  int mdl_idx = 0, mdl_blk = 0;
  bit bp = 0;
  bit lat_arm = 0, got_in = 0, got_out = 0;
  int in_cyc = 0, out_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, round magnitude half away from zero, clip symmetric.
  function automatic exp_t mk(input int d, input int r, input int ch, input bit last);
    exp_t e;
    longint p, mag, q;
    p = longint'(d) * longint'(r);
    mag = (p < 0) ? -p : p;
    q = (mag + longint'(2**(SHIFT-1))) / longint'(2**SHIFT);
    e.sat = (q > MAXV);
    if (e.sat) q = MAXV;
    e.data = (p < 0) ? -int'(q) : int'(q);
    e.ch = ch;
    e.last = last;
    return e;
  endfunction

  task automatic mdl_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 64; a++)
        mdl_tbl[c][a] = 2**SHIFT;
    mdl_idx = 0;
    mdl_blk = 0;
    sbq.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Input monitor: the model reads the table before applying a same-cycle write.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (s_valid && s_ready) begin
        if (mdl_idx == 0) mdl_blk = (int'(s_ch) >= NUM_CH) ? 0 : int'(s_ch);
        sbq.push_back(mk(int'(s_data), mdl_tbl[mdl_blk][mdl_idx], mdl_blk, mdl_idx == 63));
        mdl_idx = (mdl_idx + 1) % 64;
        if (lat_arm && !got_in) begin got_in = 1; in_cyc = cyc; end
      end
      if (tbl_wr_en && int'(tbl_wr_ch) < NUM_CH)
        mdl_tbl[tbl_wr_ch][tbl_wr_addr] = int'(tbl_wr_data);
    end
  end

  initial begin : out_mon
    bit hold;
    int h_data, h_ch, h_last, h_sat;
    exp_t e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), h_data);
        chk("hold_ch", int'(m_ch), h_ch);
        chk("hold_last", int'(m_last), h_last);
        chk("hold_sat", int'(m_sat), h_sat);
      end
      if (lat_arm && !got_out && m_valid) begin got_out = 1; out_cyc = cyc; end
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_output: got data %0d expected no output", int'(m_data));
        end else begin
          e = sbq.pop_front();
          chk("data", int'(m_data), e.data);
          chk("ch", int'(m_ch), e.ch);
          chk("last", int'(m_last), int'(e.last));
          chk("sat", int'(m_sat), int'(e.sat));
        end
      end
      hold   = m_valid && !m_ready;
      h_data = int'(m_data);
      h_ch   = int'(m_ch);
      h_last = int'(m_last);
      h_sat  = int'(m_sat);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input int ch, input bit wr = 0, input int wch = 0,
                      input int waddr = 0, input int wdata = 0);
    int n;
    s_valid = 1'b1;
    s_data  = d[IN_W-1:0];
    s_ch    = ch[CH_W-1:0];
    tbl_wr_en   = wr;
    tbl_wr_ch   = wch[CH_W-1:0];
    tbl_wr_addr = waddr[5:0];
    tbl_wr_data = wdata[RECIP_W-1:0];
    n = 0;
    do begin @(negedge clk); n++; end while (!s_ready && n < 1000);
    if (n >= 1000) begin
      n_checks++;
      n_errs++;
      $display("FAIL accept_timeout: got no s_ready in %0d cycles expected acceptance", n);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    tbl_wr_en = 1'b0;
  endtask

  task automatic wr_tbl(input int ch, input int addr, input int data);
    tbl_wr_en   = 1'b1;
    tbl_wr_ch   = ch[CH_W-1:0];
    tbl_wr_addr = addr[5:0];
    tbl_wr_data = data[RECIP_W-1:0];
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 5000) begin @(posedge clk); #1; n++; end
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    tbl_wr_en = 1'b0;
    rst = 1'b0;
    mdl_reset();
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_ch", int'(m_ch), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_sat", int'(m_sat), 0);
    chk("rst_err_ch", int'(err_ch), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    apply_reset();

    // Default tables are unity: output equals input, m_last on the 64th.
    lat_arm = 1;
    for (int k = 0; k < 64; k++) send(k - 32, 0);
    drain();
    lat_arm = 0;
    chk("latency", (got_in && got_out) ? out_cyc - in_cyc : -1, 3);

    // Rounding with Q=16; the channel-3 write must be ignored.
    for (int a = 0; a < 4; a++) wr_tbl(1, a, 256);
    wr_tbl(3, 0, 1);
    send(24, 1); send(-24, 1); send(23, 1); send(-8, 1);
    for (int k = 4; k < 64; k++) send($urandom_range(0, 400) - 200, 1);
    drain();

    // Random backpressure, gaps, table writes and channels over two blocks.
    bp = 1;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 7) == 0)
          wr_tbl($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(1, 8191));
        idle($urandom_range(0, 1));
        send($urandom_range(0, 2047) - 1024, (k == 0) ? $urandom_range(0, 2) : $urandom_range(0, 3));
      end
    drain();
    bp = 0;

    // Saturation edges with x2 factor, and the +/-127 boundary at unity.
    wr_tbl(2, 0, 8192); wr_tbl(2, 1, 8192); wr_tbl(2, 2, 4096); wr_tbl(2, 3, 4096);
    send(100, 2); send(-100, 2); send(127, 2); send(-128, 2);
    for (int k = 4; k < 64; k++) send($urandom_range(0, 200) - 100, 2);
    drain();

    // Write to idx5 in the same cycle idx5 is accepted: old factor, then halved.
    wr_tbl(0, 5, 4096);
    for (int k = 0; k < 64; k++) send((k == 5) ? 100 : $urandom_range(0, 100) - 50, 0, k == 5, 0, 5, 2048);
    for (int k = 0; k < 64; k++) send((k == 5) ? 100 : $urandom_range(0, 100) - 50, 0);
    drain();

    // Out-of-range channel maps to ch0 and sets the sticky error; reset clears mid-block.
    for (int k = 0; k < 64; k++) send($urandom_range(0, 300) - 150, (k == 0) ? 3 : 1);
    drain();
    chk("err_ch_set", int'(err_ch), 1);
    for (int k = 0; k < 20; k++) send($urandom_range(0, 300) - 150, 2);
    chk("err_ch_sticky", int'(err_ch), 1);
    apply_reset();
    for (int k = 0; k < 64; k++) send((k < 4) ? 24 : $urandom_range(0, 300) - 150, 1);
    drain();
    chk("err_ch_after_rst", int'(err_ch), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
